// File: rtl/bit_counter_if.sv
// Operand, control strobes and result signals of the bit_counter block.
// The master side drives the operand and strobes; the slave side is the counter itself.
interface bit_counter_if;
    logic       w;
    logic       LA;
    logic       EA;
    logic       LB;
    logic       EB;
    logic [3:0] Data;
    logic [3:0] A;
    logic [2:0] B;
    logic       z;
    logic       a0;

    modport master (
        output w, LA, EA, LB, EB, Data,
        input  A, B, z, a0
    );

    modport slave (
        input  w, LA, EA, LB, EB, Data,
        output A, B, z, a0
    );
endinterface

// File: rtl/bit_counter.sv
// Population count of a 4-bit operand using a right-shift register A and a 3-bit counter B,
// driven either by external strobes (w=0) or by an internal shift-and-count sequencer (w=1).
module bit_counter (
    input  logic          clk,
    input  logic          rst,
    bit_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        S1 = 2'b00,
        S2 = 2'b01,
        S3 = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic       z_w;

    assign z_w = (a_q == 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S1;
            a_q     <= 4'b0000;
            b_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (!bus.w) begin
            // Leaving S2/S3 holds the datapath for one edge; strobes only act from S1.
            state_d = S1;
            if (state_q == S1) begin
                if (bus.LA) begin
                    a_d = bus.Data;
                end else if (bus.EA) begin
                    a_d = {1'b0, a_q[3:1]};
                end
                if (bus.LB) begin
                    b_d = 3'd0;
                end else if (bus.EB) begin
                    b_d = b_q + 3'd1;
                end
            end
        end else begin
            case (state_q)
                S1: begin
                    a_d     = bus.Data;
                    b_d     = 3'd0;
                    state_d = S2;
                end
                S2: begin
                    if (!z_w) begin
                        a_d = {1'b0, a_q[3:1]};
                        if (a_q[0]) begin
                            b_d = b_q + 3'd1;
                        end
                    end else begin
                        state_d = S3;
                    end
                end
                S3: begin
                    state_d = S3;
                end
                default: begin
                    state_d = S1;
                end
            endcase
        end
    end

    assign bus.A  = a_q;
    assign bus.B  = b_q;
    assign bus.z  = z_w;
    assign bus.a0 = a_q[0];

endmodule

// File: tb/tb_bit_counter.sv
// Scoreboard bench for bit_counter: stimulus pushes the reference model's expected A/B per edge,
// a negedge monitor pops and compares against the DUT.
module tb_bit_counter;

    logic clk;
    logic rst;

    bit_counter_if bus ();

    bit_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    a;
        int    b;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "reset";

    // Reference model: plain integers, phase 0 = idle/manual, 1 = counting, 2 = done.
    int m_a = 0;
    int m_b = 0;
    int m_phase = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0;
        m_b = 0;
        m_phase = 0;
    endtask

    task automatic model_step(input logic w, input logic la, input logic ea,
                              input logic lb, input logic eb, input int data);
        case (m_phase)
            0: begin
                if (w) begin
                    m_a = data;
                    m_b = 0;
                    m_phase = 1;
                end else begin
                    if (la) m_a = data;
                    else if (ea) m_a = m_a / 2;
                    if (lb) m_b = 0;
                    else if (eb) m_b = (m_b + 1) % 8;
                end
            end
            1: begin
                if (!w) m_phase = 0;
                else if (m_a == 0) m_phase = 2;
                else begin
                    m_b = (m_b + (m_a % 2)) % 8;
                    m_a = m_a / 2;
                end
            end
            default: begin
                if (!w) m_phase = 0;
            end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.a = m_a;
        e.b = m_b;
        e.tag = cur_tag;
        exp_q.push_back(e);
    endtask

    // Called in the low phase: drive, take one edge, model it, return after the next negedge.
    task automatic step(input logic w, input logic la, input logic ea,
                        input logic lb, input logic eb, input logic [3:0] data);
        bus.w = w; bus.LA = la; bus.EA = ea; bus.LB = lb; bus.EB = eb; bus.Data = data;
        @(posedge clk);
        model_step(w, la, ea, lb, eb, int'(data));
        push_exp();
        @(negedge clk);
    endtask

    // Reset asserted mid low-phase so only an asynchronous clear can satisfy the immediate check.
    task automatic async_reset(input int hold_edges);
        #1;
        rst = 1'b0;
        #1;
        check({cur_tag, "_async_A"}, int'(bus.A), 0);
        check({cur_tag, "_async_B"}, int'(bus.B), 0);
        check({cur_tag, "_async_z"}, int'(bus.z), 1);
        check({cur_tag, "_async_a0"}, int'(bus.a0), 0);
        model_reset();
        repeat (hold_edges) begin
            @(posedge clk);
            push_exp();
            @(negedge clk);
        end
        #1;
        rst = 1'b1;
    endtask

    task automatic run_auto(input logic [3:0] data);
        cur_tag = "auto";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, data);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end
        check("auto_popcount", int'(bus.B), $countones(data));
        check("auto_final_z", int'(bus.z), 1);
        $display("auto data=%b B=%0d A=%b", data, bus.B, bus.A);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_A"}, int'(bus.A), e.a);
            check({e.tag, "_B"}, int'(bus.B), e.b);
            check({e.tag, "_z"}, int'(bus.z), (e.a == 0) ? 1 : 0);
            check({e.tag, "_a0"}, int'(bus.a0), e.a % 2);
        end
    end

    initial begin
        logic w_r;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic w_r;
        rst = 1'b0;
        bus.w = 1'b0; bus.LA = 1'b1; bus.EA = 1'b0; bus.LB = 1'b0; bus.EB = 1'b0;
        bus.Data = 4'b1011;
        #1;
        check("reset_A", int'(bus.A), 0);
        check("reset_B", int'(bus.B), 0);
        check("reset_z", int'(bus.z), 1);
        check("reset_a0", int'(bus.a0), 0);
        repeat (2) begin
            @(posedge clk);
            push_exp();
            @(negedge clk);
        end
        #1;
        rst = 1'b1;

        cur_tag = "man_load";
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        cur_tag = "man_shift";
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110);
        cur_tag = "man_clrB";
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cur_tag = "man_incB";
        repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        cur_tag = "man_lb_over_eb";
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        cur_tag = "man_la_over_ea";
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100);

        run_auto(4'b1011);
        run_auto(4'b1000);
        run_auto(4'b0000);
        run_auto(4'b1111);

        cur_tag = "midop";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
        bus.w = 1'b1;
        async_reset(2);
        run_auto(4'b1011);

        cur_tag = "idle_return";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);

        cur_tag = "drop_in_count";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);

        cur_tag = "random";
        w_r = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) w_r = ~w_r;
            if ($urandom_range(0, 149) == 0) begin
                bus.w = w_r;
                async_reset(1);
            end
            step(w_r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
